// File: rtl/noc_out_port_arbiter.sv
// Round-robin arbiter and one-entry forwarding register for a single router output port.
// Pops one packet per grant from the input buffers and writes it into the downstream link buffer.
module noc_out_port_arbiter #(
   parameter int PAC_WIDTH = 64,
   parameter int NUM_REQ   = 5,
   parameter int ID_W      = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           in_empty,
   input  logic [NUM_REQ*PAC_WIDTH-1:0] in_data,
   output logic [NUM_REQ-1:0]           in_ren,
   input  logic                         out_full,
   output logic                         out_wen,
   output logic [PAC_WIDTH-1:0]         out_data,
   output logic [ID_W-1:0]              last_grant,
   output logic [15:0]                  fwd_count
);

   logic [NUM_REQ-1:0]   req_p0;
   logic [PAC_WIDTH-1:0] pkt_p0 [NUM_REQ];
   logic [ID_W:0]        pick_p0;
   logic                 can_accept_p0;
   logic                 grant_vld_p0;
   logic [ID_W-1:0]      grant_id_p0;
   logic [ID_W-1:0]      rr_ptr;
   logic                 vld_p1;
   logic [PAC_WIDTH-1:0] data_p1;

   // Returns {found, index}; scanning from the far end lets the requester closest to ptr win.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [ID_W-1:0]    ptr);
      logic [ID_W:0] pick;
      int            idx;
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) pick = {1'b1, ID_W'(idx)};
      end
      return pick;
   endfunction

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
      return (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign pkt_p0[i] = in_data[i*PAC_WIDTH +: PAC_WIDTH];
   end

   // ---- stage p0: request selection against the input buffers ----
   assign req_p0        = ~in_empty;
   assign can_accept_p0 = ~vld_p1 | ~out_full;
   assign pick_p0       = rr_pick(req_p0, rr_ptr);
   assign grant_vld_p0  = pick_p0[ID_W] & can_accept_p0 & reset;
   assign grant_id_p0   = pick_p0[ID_W-1:0];

   always_comb begin
      in_ren = '0;
      if (grant_vld_p0) in_ren[grant_id_p0] = 1'b1;
   end

   // ---- stage p1: output register feeding the downstream buffer ----
   assign out_wen  = vld_p1 & ~out_full & reset;
   assign out_data = data_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1     <= 1'b0;
         data_p1    <= '0;
         rr_ptr     <= '0;
         last_grant <= '0;
         fwd_count  <= '0;
      end else begin
         if (grant_vld_p0) begin
            vld_p1     <= 1'b1;
            data_p1    <= pkt_p0[grant_id_p0];
            last_grant <= grant_id_p0;
            rr_ptr     <= next_ptr(grant_id_p0);
         end else if (out_wen) begin
            vld_p1 <= 1'b0;
         end
         if (out_wen) fwd_count <= fwd_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Bench for noc_out_port_arbiter: vector table plus hand sequences, with a packet scoreboard.
`timescale 1ns/1ps
module tb_noc_out_port_arbiter;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [4:0]   in_empty = 5'h1f;
   logic [319:0] in_data;
   logic [4:0]   in_ren;
   logic         out_full = 1'b0;
   logic         out_wen;
   logic [63:0]  out_data;
   logic [2:0]   last_grant;
   logic [15:0]  fwd_count;

   logic [63:0]  src [5];
   logic [63:0]  sb [$];
   logic [15:0]  exp_cnt;
   int           n_chk = 0;
   int           n_fail = 0;

   typedef struct packed {
      logic       rst;
      logic [4:0] empty;
      logic       full;
      logic [4:0] ren;
      logic       wen;
      logic [2:0] lg;
   } vec_t;
   vec_t tbl [$];

   assign in_data = {src[4], src[3], src[2], src[1], src[0]};

   always #5 clk = ~clk;

   noc_out_port_arbiter #(.PAC_WIDTH(64), .NUM_REQ(5), .ID_W(3)) dut (
      .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data), .in_ren(in_ren),
      .out_full(out_full), .out_wen(out_wen), .out_data(out_data),
      .last_grant(last_grant), .fwd_count(fwd_count)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic [4:0] e, input logic f,
                               input logic [4:0] r, input logic w, input logic [2:0] lg);
      vec_t v;
      v.rst = rst; v.empty = e; v.full = f; v.ren = r; v.wen = w; v.lg = lg;
      return v;
   endfunction

   // Starts and ends on a falling edge.
   task automatic cycle(input logic [4:0] e, input logic f, input logic [4:0] xren,
                        input logic xwen, input logic [2:0] xlg, input bit chk);
      int g;
      logic [63:0] exp_pkt;
      in_empty = e;
      out_full = f;
      #1;
      if (chk) begin
         check("in_ren", 64'(in_ren), 64'(xren));
         check("out_wen", 64'(out_wen), 64'(xwen));
         check("last_grant", 64'(last_grant), 64'(xlg));
         check("fwd_count", 64'(fwd_count), 64'(exp_cnt));
         if (sb.size() > 0) check("out_data_held", out_data, sb[0]);
      end
      if (out_wen) begin
         if (sb.size() == 0) begin
            check("write_without_pop", 64'(out_wen), 64'd0);
         end else begin
            exp_pkt = sb.pop_front();
            if (chk) check("out_data", out_data, exp_pkt);
         end
      end
      g = -1;
      for (int i = 0; i < 5; i++) if (xren[i]) g = i;
      if (g >= 0) sb.push_back(src[g]);
      if (xwen) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
      if (g >= 0) src[g] = src[g] + 64'd1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_empty = 5'b00000;
      out_full = 1'b0;
      #1;
      check("rst_in_ren", 64'(in_ren), 64'd0);
      check("rst_out_wen", 64'(out_wen), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_last_grant", 64'(last_grant), 64'd0);
      check("rst_fwd_count", 64'(fwd_count), 64'd0);
      @(posedge clk);
      @(negedge clk);
      in_empty = 5'b11111;
      reset = 1'b1;
      sb.delete();
      exp_cnt = '0;
   endtask

   initial begin
      int m;
      exp_cnt = '0;
      for (int i = 0; i < 5; i++) src[i] = {8'(i + 1), 56'h0};

      // Reset held for two cycles with random inputs
      for (int c = 0; c < 2; c++) begin
         in_empty = 5'($urandom);
         out_full = 1'($urandom);
         for (int i = 0; i < 5; i++) src[i] = {$urandom, $urandom};
         @(negedge clk);
         #1;
         check("reset_in_ren", 64'(in_ren), 64'd0);
         check("reset_out_wen", 64'(out_wen), 64'd0);
         check("reset_out_data", out_data, 64'd0);
         check("reset_fwd_count", 64'(fwd_count), 64'd0);
         check("reset_last_grant", 64'(last_grant), 64'd0);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) src[i] = {8'(i + 1), 56'h0};
      src[2] = 64'hDEAD_BEEF_0123_4567;
      in_empty = 5'b11111;
      out_full = 1'b0;
      reset = 1'b1;

      // Single requester
      tbl.push_back(mk(0, 5'b11011, 0, 5'b00100, 0, 3'd0));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 1, 3'd2));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 0, 3'd2));
      // Round robin from a fresh reset
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(k == 0, 5'b00000, 0, 5'(1 << (k % 5)), k > 0,
                          (k == 0) ? 3'd0 : 3'((k - 1) % 5)));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 1, 3'd4));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 0, 3'd4));
      // Wrap and skip: steer rr_ptr to 4, then only 0 and 4 pending
      tbl.push_back(mk(0, 5'b10111, 0, 5'b01000, 0, 3'd4));
      tbl.push_back(mk(0, 5'b01110, 0, 5'b10000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b01110, 0, 5'b00001, 1, 3'd4));
      tbl.push_back(mk(0, 5'b11110, 0, 5'b00001, 1, 3'd0));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 1, 3'd0));
      tbl.push_back(mk(0, 5'b11111, 0, 5'b00000, 0, 3'd0));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         cycle(tbl[i].empty, tbl[i].full, tbl[i].ren, tbl[i].wen, tbl[i].lg, 1'b1);
      end

      // Backpressure: A from requester 0 held while 1 and 3 wait
      cycle(5'b11110, 0, 5'b00001, 0, 3'd0, 1'b1);
      for (int k = 0; k < 3; k++) cycle(5'b10101, 1, 5'b00000, 0, 3'd0, 1'b1);
      cycle(5'b10101, 0, 5'b00010, 1, 3'd0, 1'b1);
      cycle(5'b10101, 0, 5'b01000, 1, 3'd1, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 1, 3'd3, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 0, 3'd3, 1'b1);

      // Reset while the output register is blocked
      cycle(5'b11101, 1, 5'b00010, 0, 3'd3, 1'b1);
      cycle(5'b11111, 1, 5'b00000, 0, 3'd1, 1'b1);
      do_reset();
      cycle(5'b11111, 0, 5'b00000, 0, 3'd0, 1'b1);
      cycle(5'b00000, 0, 5'b00001, 0, 3'd0, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 1, 3'd0, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 0, 3'd0, 1'b1);

      // Stream requester 2 until fwd_count sits at 0xFFFE, then watch it wrap
      m = 32'hFFFE - int'(exp_cnt) + 1;
      for (int i = 0; i < m; i++) cycle(5'b11011, 0, 5'b00100, i > 0, 3'd2, 1'b0);
      cycle(5'b11011, 0, 5'b00100, 1, 3'd2, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 1, 3'd2, 1'b1);
      cycle(5'b11111, 0, 5'b00000, 0, 3'd2, 1'b1);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
